// File: rtl/dual_counter_pkg.sv
// dual_counter_pkg: shared op encoding and width-generic saturating add/sub helpers for counters.
package dual_counter_pkg;
  typedef enum logic [1:0] {OP_HOLD, OP_LOAD, OP_SWAP, OP_COUNT} dc_op_e;
  localparam int MAX_W = 32;
  // Operands live in MAX_W-bit containers; w selects the active width so one function serves any counter.
  function automatic logic [MAX_W-1:0] sat_add(input logic [MAX_W-1:0] a, input logic [MAX_W-1:0] b, input int w, input logic sat);
    logic [MAX_W:0] s;
    logic [MAX_W-1:0] lim;
    lim = {MAX_W{1'b1}} >> (MAX_W - w);
    s = {1'b0, a} + {1'b0, b};
    return (sat && s > {1'b0, lim}) ? lim : s[MAX_W-1:0] & lim;
  endfunction
  function automatic logic [MAX_W-1:0] sat_sub(input logic [MAX_W-1:0] a, input logic [MAX_W-1:0] b, input int w, input logic sat);
    logic [MAX_W-1:0] lim;
    lim = {MAX_W{1'b1}} >> (MAX_W - w);
    return (sat && b > a) ? '0 : (a - b) & lim;
  endfunction
endpackage

// File: rtl/rise_detect.sv
// rise_detect: one-cycle rising-edge pulse from a level input, with its registered history bit.
module rise_detect (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic pulse,
  output logic hist
);
  logic hist_q, hist_d;
  always_comb hist_d = d;
  always_ff @(posedge clock) hist_q <= reset ? 1'b0 : hist_d;
  assign hist = hist_q;
  assign pulse = d & ~hist_q;
endmodule

// File: rtl/dual_counter_swap.sv
// dual_counter_swap: up/down counter pair with load, edge-qualified swap with ack, terminal-count flags.
// Saturation mode is built only with DUAL_COUNTER_SAT_EN; otherwise the sat port is ignored.
module dual_counter_swap
  import dual_counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int STEP     = 1,
  parameter int UP_RST   = 0,
  parameter int DOWN_RST = 2**WIDTH - 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             swap,
  input  logic             load,
  input  logic [WIDTH-1:0] load_up,
  input  logic [WIDTH-1:0] load_down,
  input  logic             sat,
  output logic [WIDTH-1:0] upcount,
  output logic [WIDTH-1:0] downcount,
  output logic             up_tc,
  output logic             down_tc,
  output logic             swap_ack
);
  logic [WIDTH-1:0] up_q, up_d, down_q, down_d, up_inc, down_dec;
  logic ack_q, ack_d, swap_edge, swap_hist, sat_on;
  dc_op_e op;
`ifdef DUAL_COUNTER_SAT_EN
  assign sat_on = sat;
`else
  logic sat_unused;
  assign sat_unused = sat;
  assign sat_on = 1'b0;
`endif
  rise_detect u_rise (
    .clock (clock),
    .reset (reset),
    .d     (swap),
    .pulse (swap_edge),
    .hist  (swap_hist)
  );
  always_comb begin
    op = load ? OP_LOAD : (enable & swap_edge) ? OP_SWAP : enable ? OP_COUNT : OP_HOLD;
    up_inc = WIDTH'(sat_add(MAX_W'(up_q), MAX_W'(STEP), WIDTH, sat_on));
    down_dec = WIDTH'(sat_sub(MAX_W'(down_q), MAX_W'(STEP), WIDTH, sat_on));
    up_d = op == OP_LOAD ? load_up : op == OP_SWAP ? down_q : op == OP_COUNT ? up_inc : up_q;
    down_d = op == OP_LOAD ? load_down : op == OP_SWAP ? up_q : op == OP_COUNT ? down_dec : down_q;
    ack_d = op == OP_SWAP;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      up_q <= WIDTH'(UP_RST);
      down_q <= WIDTH'(DOWN_RST);
      ack_q <= 1'b0;
    end else begin
      up_q <= up_d;
      down_q <= down_d;
      ack_q <= ack_d;
    end
  end
  logic hist_unused;
  assign hist_unused = swap_hist;
  assign upcount = up_q;
  assign downcount = down_q;
  assign swap_ack = ack_q;
  assign up_tc = &up_q;
  assign down_tc = ~|down_q;
endmodule
